// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the bank and the pipeline controllers.
package regfile_pkg;

    parameter int unsigned XLEN     = 32;
    parameter int unsigned REG_AW   = 5;
    parameter int unsigned NUM_REGS = 32;

    // Writeback arbiter priority state
    typedef enum logic {
        PRIO_MEM,
        FORCE_ALU
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc and stick at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register bank write port between the ALU and load writeback paths.
// Loads normally win; an ALU request that loses MAX_WAIT times in a row is forced through.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [3:0] WaitLimit = 4'(MAX_WAIT - 1);

    arb_state_t state, stateNext;
    logic [3:0] waitCnt, waitNext;
    logic       aluGrant, memGrant, aluLoses;

    // Grant decision; depends only on valids, state and reset
    always_comb begin
        aluGrant = 1'b0;
        memGrant = 1'b0;
        if (!rst) begin
            if ((state == FORCE_ALU) && alu_valid) begin
                aluGrant = 1'b1;
            end else if (mem_valid) begin
                memGrant = 1'b1;
            end else if (alu_valid) begin
                aluGrant = 1'b1;
            end
        end
    end

    assign alu_ready = aluGrant;
    assign mem_ready = memGrant;
    assign aluLoses  = alu_valid && !aluGrant;

    // Starvation tracking and priority state next-state
    always_comb begin
        stateNext = state;
        waitNext  = 4'd0;
        if (aluLoses && (waitCnt != 4'hF)) begin
            waitNext = waitCnt + 4'd1;
        end
        unique case (state)
            PRIO_MEM: begin
                if (aluLoses && (waitCnt == WaitLimit)) begin
                    stateNext = FORCE_ALU;
                end
            end
            FORCE_ALU: begin
                // ALU either got through or withdrew; start counting afresh
                if (aluGrant || !alu_valid) begin
                    stateNext = PRIO_MEM;
                    waitNext  = 4'd0;
                end
            end
            default: stateNext = PRIO_MEM;
        endcase
    end

    // Priority state and loss counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PRIO_MEM;
            waitCnt <= 4'd0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
        end
    end

    // Register the winning write; x0 is accepted but never enables the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (aluGrant) begin
            rf_we    <= (alu_rd != '0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (memGrant) begin
            rf_we    <= (mem_rd != '0);
            rf_waddr <= mem_rd;
            rf_wdata <= mem_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (alu_valid && mem_valid),
        .count (conflict_cnt)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a behavioural writeback model.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;

    logic        alu_ready, mem_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] conflict_cnt;

    logic        satAluReady, satMemReady, satRfWe;
    logic [4:0]  satWaddr;
    logic [31:0] satWdata;
    logic [3:0]  satCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          losses;
    logic        mWe;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    logic [15:0] mCnt;
    logic [3:0]  mCnt4;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(satAluReady),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(satMemReady),
        .rf_we(satRfWe), .rf_waddr(satWaddr), .rf_wdata(satWdata), .conflict_cnt(satCnt)
    );

    // ALU wins when loads are idle or after MAX_WAIT consecutive losses
    function automatic logic modelAluWins();
        return alu_valid && ((losses >= MAX_WAIT) || !mem_valid);
    endfunction

    function automatic logic modelMemWins();
        return mem_valid && !modelAluWins();
    endfunction

    task automatic modelReset();
        losses = 0;
        mWe    = 1'b0;
        mAddr  = '0;
        mData  = '0;
        mCnt   = '0;
        mCnt4  = '0;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    // Advance one clock and update the model with what the edge committed
    task automatic cycle();
        logic aw, mw;
        aw = modelAluWins();
        mw = modelMemWins();
        @(posedge clk);
        if (aw) begin
            mWe = (alu_rd != 5'd0); mAddr = alu_rd; mData = alu_data;
        end else if (mw) begin
            mWe = (mem_rd != 5'd0); mAddr = mem_rd; mData = mem_data;
        end else begin
            mWe = 1'b0;
        end
        losses = (alu_valid && !aw) ? losses + 1 : 0;
        if (alu_valid && mem_valid) begin
            if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
            if (mCnt4 != 4'hF) mCnt4 = mCnt4 + 4'd1;
        end
        #1;
    endtask

    task automatic doReset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", rf_we); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", rf_wdata); end
        rst = 1'b0;
        modelReset();
        drive(1'b1, 5'd4, 32'h11, 1'b1, 5'd7, 32'h77);
        #1;
        cycle();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL pre_reset_write: got we=%0h addr=%0h expected we=1 addr=7", rf_we, rf_waddr); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0h expected 1", conflict_cnt); end
        // Reset lands between edges and must act immediately
        #2 rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL async_reset_rf: got we=%0h addr=%0h expected we=0 addr=0", rf_we, rf_waddr); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_cnt: got %0h expected 0", conflict_cnt); end
        checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got alu=%0h mem=%0h expected 0 0", alu_ready, mem_ready); end
        doReset();
    endtask

    task automatic test_single_alu();
        doReset();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got alu=%0h mem=%0h expected 1 0", alu_ready, mem_ready); end
        cycle();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got we=%0h addr=%0h data=%0h expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5) begin errors++; $display("FAIL single_idle: got we=%0h addr=%0h expected 0 5", rf_we, rf_waddr); end
    endtask

    task automatic test_x0_discard();
        doReset();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %0h expected 1", mem_ready); end
        cycle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %0h expected 0", rf_we); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we_after: got %0h expected 0", rf_we); end
    endtask

    task automatic test_contention();
        doReset();
        drive(1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd3, 32'hBBBB0002);
        #1;
        checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL contend_first: got alu=%0h mem=%0h expected 0 1", alu_ready, mem_ready); end
        cycle();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hBBBB0002) begin errors++; $display("FAIL contend_mem_write: got we=%0h addr=%0h data=%0h expected 1 3 bbbb0002", rf_we, rf_waddr, rf_wdata); end
        mem_valid = 1'b0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL contend_second: got %0h expected 1", alu_ready); end
        cycle();
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hAAAA0001) begin errors++; $display("FAIL contend_alu_write: got we=%0h data=%0h expected 1 aaaa0001", rf_we, rf_wdata); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("FAIL contend_cnt: got %0h expected 1", conflict_cnt); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_starvation();
        doReset();
        drive(1'b1, 5'd10, 32'hA10, 1'b1, 5'd11, 32'hB11);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (alu_ready !== (i == 3) || mem_ready !== (i != 3)) begin errors++; $display("FAIL starve_grant%0d: got alu=%0h mem=%0h expected %0h %0h", i, alu_ready, mem_ready, (i == 3), (i != 3)); end
            cycle();
            checks++; if (conflict_cnt !== 16'(i + 1)) begin errors++; $display("FAIL starve_cnt%0d: got %0h expected %0h", i, conflict_cnt, i + 1); end
        end
        checks++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'hA10) begin errors++; $display("FAIL starve_alu_write: got addr=%0h data=%0h expected a a10", rf_waddr, rf_wdata); end
        alu_valid = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL starve_mem_resume: got %0h expected 1", mem_ready); end
        cycle();
        checks++; if (rf_waddr !== 5'd11) begin errors++; $display("FAIL starve_mem_write: got %0h expected b", rf_waddr); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_saturation();
        doReset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            checks++; if (satCnt !== 4'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_cnt%0d: got %0h expected %0h", k, satCnt, (k > 15) ? 15 : k); end
            checks++; if (conflict_cnt !== 16'(k)) begin errors++; $display("FAIL wide_cnt%0d: got %0h expected %0h", k, conflict_cnt, k); end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_random();
        logic aw, mw;
        doReset();
        aw = 1'b0;
        mw = 1'b0;
        for (int n = 0; n < 400; n++) begin
            // Pending requests mostly stay up; the ALU may occasionally withdraw
            if (!(alu_valid && !aw && ($urandom_range(0, 7) != 0))) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!(mem_valid && !mw)) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_rd    = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            #1;
            aw = modelAluWins();
            mw = modelMemWins();
            checks++; if (alu_ready !== aw || mem_ready !== mw) begin errors++; $display("FAIL rand_ready%0d: got alu=%0h mem=%0h expected %0h %0h", n, alu_ready, mem_ready, aw, mw); end
            checks++; if (satAluReady !== aw || satMemReady !== mw) begin errors++; $display("FAIL rand_sat_ready%0d: got alu=%0h mem=%0h expected %0h %0h", n, satAluReady, satMemReady, aw, mw); end
            cycle();
            checks++; if (rf_we !== mWe || rf_waddr !== mAddr || rf_wdata !== mData) begin errors++; $display("FAIL rand_rf%0d: got we=%0h addr=%0h data=%0h expected %0h %0h %0h", n, rf_we, rf_waddr, rf_wdata, mWe, mAddr, mData); end
            checks++; if (satRfWe !== mWe || satWaddr !== mAddr || satWdata !== mData) begin errors++; $display("FAIL rand_sat_rf%0d: got we=%0h addr=%0h data=%0h expected %0h %0h %0h", n, satRfWe, satWaddr, satWdata, mWe, mAddr, mData); end
            checks++; if (conflict_cnt !== mCnt || satCnt !== mCnt4) begin errors++; $display("FAIL rand_cnt%0d: got %0h/%0h expected %0h/%0h", n, conflict_cnt, satCnt, mCnt, mCnt4); end
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    initial begin
        modelReset();
        #1;
        test_reset();
        test_single_alu();
        test_x0_discard();
        test_contention();
        test_starvation();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
